// File: rtl/ptw_mem_arbiter.sv
// ptw_mem_arbiter
//   Arbitrates page-table-walk reads from the IFU and LSU MMUs onto a single
//   memory read port. At most one read is outstanding. Ties are broken
//   round-robin. A wait-cycle timeout returns an error completion to the
//   owner, and the late response is drained afterwards.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   if_mem_req_i / if_mem_addr_i      IFU request (level) and PTE address
//   if_mem_rdata_o/_rvalid_o/_err_o   IFU completion (1-cycle pulse)
//   ls_mem_req_i / ls_mem_addr_i      LSU request (level) and PTE address
//   ls_mem_rdata_o/_rvalid_o/_err_o   LSU completion (1-cycle pulse)
//   if_flush_i                        abort any IFU-owned walk
//   mem_req_valid_o / mem_addr_o      memory read request
//   mem_req_ready_i                   memory request accept
//   mem_rdata_i / mem_rvalid_i        memory read response
//   busy_o                            arbiter not idle
module ptw_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_mem_req_i,
  input  logic [31:0] if_mem_addr_i,
  output logic [31:0] if_mem_rdata_o,
  output logic        if_mem_rvalid_o,
  output logic        if_mem_err_o,
  input  logic        ls_mem_req_i,
  input  logic [31:0] ls_mem_addr_i,
  output logic [31:0] ls_mem_rdata_o,
  output logic        ls_mem_rvalid_o,
  output logic        ls_mem_err_o,
  input  logic        if_flush_i,
  output logic        mem_req_valid_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_req_ready_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;      // 0 = IFU, 1 = LSU
  logic        rr_last_q, rr_last_d;  // owner most recently served
  logic [31:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;

  logic        if_elig;
  logic        grant_ls;
  logic        ifu_flush;
  logic        done;
  logic        done_err;
  logic [31:0] done_data;

  // A flushing IFU cannot win arbitration; on a tie the LSU wins only when
  // the IFU was served last.
  assign if_elig   = if_mem_req_i & ~if_flush_i;
  assign grant_ls  = ls_mem_req_i & (~if_elig | ~rr_last_q);
  assign ifu_flush = if_flush_i & ~owner_q;

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    rr_last_d       = rr_last_q;
    addr_d          = addr_q;
    cnt_d           = cnt_q;
    mem_req_valid_o = 1'b0;
    mem_addr_o      = '0;
    done            = 1'b0;
    done_err        = 1'b0;
    done_data       = '0;

    case (state_q)
      S_IDLE: begin
        if (if_elig || ls_mem_req_i) begin
          owner_d = grant_ls;
          addr_d  = grant_ls ? ls_mem_addr_i : if_mem_addr_i;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = addr_q;
        if (ifu_flush) begin
          // If memory takes the request in the flush cycle a response is
          // still coming; drain it so it cannot complete a later grant.
          state_d = mem_req_ready_i ? S_DRAIN : S_IDLE;
        end else if (mem_req_ready_i) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ifu_flush) begin
          state_d = mem_rvalid_i ? S_IDLE : S_DRAIN;
        end else if (mem_rvalid_i) begin
          done      = 1'b1;
          done_data = mem_rdata_i;
          rr_last_d = owner_q;
          state_d   = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          done      = 1'b1;
          done_err  = 1'b1;
          rr_last_d = owner_q;
          state_d   = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DRAIN: begin
        if (mem_rvalid_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      addr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign if_mem_rvalid_o = done & ~owner_q;
  assign if_mem_err_o    = done_err & ~owner_q;
  assign if_mem_rdata_o  = owner_q ? '0 : done_data;
  assign ls_mem_rvalid_o = done & owner_q;
  assign ls_mem_err_o    = done_err & owner_q;
  assign ls_mem_rdata_o  = owner_q ? done_data : '0;
  assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// tb_ptw_mem_arbiter
//   Directed bench for ptw_mem_arbiter (TIMEOUT=4). Expected completions are
//   queued when the memory response is driven and checked when a completion
//   pulse appears.
module tb_ptw_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_mem_req_i;
  logic [31:0] if_mem_addr_i;
  logic [31:0] if_mem_rdata_o;
  logic        if_mem_rvalid_o;
  logic        if_mem_err_o;
  logic        ls_mem_req_i;
  logic [31:0] ls_mem_addr_i;
  logic [31:0] ls_mem_rdata_o;
  logic        ls_mem_rvalid_o;
  logic        ls_mem_err_o;
  logic        if_flush_i;
  logic        mem_req_valid_o;
  logic [31:0] mem_addr_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_rdata_i;
  logic        mem_rvalid_i;
  logic        busy_o;

  typedef struct {
    logic        port;  // 0 = IFU, 1 = LSU
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ptw_mem_arbiter #(.TIMEOUT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_mem_req_i    (if_mem_req_i),
    .if_mem_addr_i   (if_mem_addr_i),
    .if_mem_rdata_o  (if_mem_rdata_o),
    .if_mem_rvalid_o (if_mem_rvalid_o),
    .if_mem_err_o    (if_mem_err_o),
    .ls_mem_req_i    (ls_mem_req_i),
    .ls_mem_addr_i   (ls_mem_addr_i),
    .ls_mem_rdata_o  (ls_mem_rdata_o),
    .ls_mem_rvalid_o (ls_mem_rvalid_o),
    .ls_mem_err_o    (ls_mem_err_o),
    .if_flush_i      (if_flush_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_addr_o      (mem_addr_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_rdata_i     (mem_rdata_i),
    .mem_rvalid_i    (mem_rvalid_i),
    .busy_o          (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Completion monitor: any pulse must match the head of the scoreboard.
  task automatic monitor();
    logic [1:0] hot;
    exp_t       e;
    hot = {if_mem_rvalid_o, ls_mem_rvalid_o};
    if (hot != 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 32'(hot), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rvalid_onehot", 32'(hot), e.port ? 32'd1 : 32'd2);
        if (e.port) begin
          chk("ls_rdata", ls_mem_rdata_o, e.data);
          chk("ls_err", 32'(ls_mem_err_o), 32'(e.err));
          chk("if_nonowner", if_mem_rdata_o | 32'(if_mem_err_o), 32'd0);
        end else begin
          chk("if_rdata", if_mem_rdata_o, e.data);
          chk("if_err", 32'(if_mem_err_o), 32'(e.err));
          chk("ls_nonowner", ls_mem_rdata_o | 32'(ls_mem_err_o), 32'd0);
        end
      end
    end else begin
      chk("quiet_outs", if_mem_rdata_o | ls_mem_rdata_o |
          32'({if_mem_err_o, ls_mem_err_o}), 32'd0);
    end
  endtask

  // One clock: sample on the falling edge, then step past the rising edge.
  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, "_flags"}, 32'({mem_req_valid_o, if_mem_rvalid_o, if_mem_err_o,
                              ls_mem_rvalid_o, ls_mem_err_o, busy_o}), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    chk({tag, "_rdata"}, if_mem_rdata_o | ls_mem_rdata_o, 32'd0);
  endtask

  // Entered in an IDLE cycle with requests already driven; returns in the
  // IDLE gap cycle after the completion, with the served requester dropped.
  task automatic serve(input logic port, input logic [31:0] addr,
                       input logic [31:0] data, input int unsigned resp_wait);
    @(negedge clk);
    chk("gnt_idle_busy", 32'(busy_o), 32'd0);
    monitor();
    @(posedge clk);
    #1;
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    chk("req_valid", 32'(mem_req_valid_o), 32'd1);
    chk("req_addr", mem_addr_o, addr);
    chk("req_busy", 32'(busy_o), 32'd1);
    monitor();
    @(posedge clk);
    #1;
    mem_req_ready_i = 1'b0;
    for (int unsigned i = 0; i < resp_wait; i++) begin
      @(negedge clk);
      chk("wait_mem_outs", mem_addr_o | 32'(mem_req_valid_o), 32'd0);
      monitor();
      @(posedge clk);
      #1;
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = data;
    sb.push_back('{port: port, data: data, err: 1'b0});
    cyc();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    if (port) ls_mem_req_i = 1'b0;
    else      if_mem_req_i = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    if_mem_req_i    = 1'b0;
    if_mem_addr_i   = '0;
    ls_mem_req_i    = 1'b0;
    ls_mem_addr_i   = '0;
    if_flush_i      = 1'b0;
    mem_req_ready_i = 1'b0;
    mem_rdata_i     = '0;
    mem_rvalid_i    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    zero_outs("reset");
    @(posedge clk);
    #1;

    // Single IFU walk, response three cycles after acceptance.
    if_mem_req_i  = 1'b1;
    if_mem_addr_i = 32'h8000_1000;
    serve(1'b0, 32'h8000_1000, 32'h2000_0CF1, 2);
    chk("t1_busy_after", 32'(busy_o), 32'd0);

    // Ties after reset: IFU first, then LSU.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if_mem_req_i  = 1'b1;
    if_mem_addr_i = 32'h0000_0100;
    ls_mem_req_i  = 1'b1;
    ls_mem_addr_i = 32'h0000_0200;
    serve(1'b0, 32'h0000_0100, 32'h1111_0001, 1);
    serve(1'b1, 32'h0000_0200, 32'h2222_0002, 0);
    // IFU served alone, so the next tie goes to the LSU.
    if_mem_req_i  = 1'b1;
    if_mem_addr_i = 32'h0000_0300;
    serve(1'b0, 32'h0000_0300, 32'h3333_0003, 3);
    if_mem_req_i  = 1'b1;
    if_mem_addr_i = 32'h0000_0400;
    ls_mem_req_i  = 1'b1;
    ls_mem_addr_i = 32'h0000_0500;
    serve(1'b1, 32'h0000_0500, 32'h5555_0005, 1);
    serve(1'b0, 32'h0000_0400, 32'h4444_0004, 2);

    // LSU request stalled by ready for 5 cycles; IFU flush has no effect.
    ls_mem_req_i  = 1'b1;
    ls_mem_addr_i = 32'h0000_7000;
    cyc();
    for (int unsigned i = 0; i < 5; i++) begin
      if_flush_i = (i == 2);
      @(negedge clk);
      chk("stall_valid", 32'(mem_req_valid_o), 32'd1);
      chk("stall_addr", mem_addr_o, 32'h0000_7000);
      monitor();
      @(posedge clk);
      #1;
    end
    if_flush_i      = 1'b0;
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    chk("stall_accept_addr", mem_addr_o, 32'h0000_7000);
    monitor();
    @(posedge clk);
    #1;
    mem_req_ready_i = 1'b0;
    if_flush_i      = 1'b1;
    cyc();
    if_flush_i   = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h7777_0007;
    sb.push_back('{port: 1'b1, data: 32'h7777_0007, err: 1'b0});
    cyc();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    ls_mem_req_i = 1'b0;
    chk("stall_sb_drained", 32'(sb.size()), 32'd0);

    // Flush in IDLE blocks the IFU grant for that cycle.
    if_mem_req_i  = 1'b1;
    if_mem_addr_i = 32'h0000_8000;
    if_flush_i    = 1'b1;
    cyc();
    chk("flush_idle_busy", 32'(busy_o), 32'd0);
    if_flush_i = 1'b0;
    cyc();
    chk("flush_idle_regrant", mem_addr_o, 32'h0000_8000);
    mem_req_ready_i = 1'b1;
    cyc();
    mem_req_ready_i = 1'b0;
    // Flush in WAIT, response two cycles later is discarded; LSU waits.
    if_flush_i    = 1'b1;
    if_mem_req_i  = 1'b0;
    ls_mem_req_i  = 1'b1;
    ls_mem_addr_i = 32'h0000_9000;
    cyc();
    if_flush_i = 1'b0;
    chk("drain_busy", 32'(busy_o), 32'd1);
    cyc();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hBAD0_0008;
    cyc();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    chk("drain_exit_busy", 32'(busy_o), 32'd0);
    serve(1'b1, 32'h0000_9000, 32'h9999_0009, 1);

    // Timeout: error completion on the 4th WAIT cycle, late data drained.
    if_mem_req_i  = 1'b1;
    if_mem_addr_i = 32'h0000_A000;
    cyc();
    mem_req_ready_i = 1'b1;
    cyc();
    mem_req_ready_i = 1'b0;
    repeat (3) cyc();
    mem_rdata_i = 32'h5555_5555;
    sb.push_back('{port: 1'b0, data: 32'h0000_0000, err: 1'b1});
    cyc();
    mem_rdata_i  = '0;
    if_mem_req_i = 1'b0;
    chk("timeout_sb_drained", 32'(sb.size()), 32'd0);
    chk("timeout_drain_busy", 32'(busy_o), 32'd1);
    repeat (2) cyc();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEAD_BEEF;
    cyc();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    chk("timeout_idle_busy", 32'(busy_o), 32'd0);

    // Reset in WAIT abandons the walk; a stray response is ignored.
    ls_mem_req_i  = 1'b1;
    ls_mem_addr_i = 32'h0000_B000;
    cyc();
    mem_req_ready_i = 1'b1;
    cyc();
    mem_req_ready_i = 1'b0;
    rst = 1'b1;
    cyc();
    rst          = 1'b0;
    ls_mem_req_i = 1'b0;
    @(negedge clk);
    zero_outs("rst_mid");
    @(posedge clk);
    #1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0000_1234;
    @(negedge clk);
    zero_outs("stray");
    monitor();
    @(posedge clk);
    #1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    @(negedge clk);
    zero_outs("after_stray");

    chk("sb_final", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptw_mem_arbiter.md
PTW_MEM_ARBITER -- requirements
Module: ptw_mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, number of WAIT cycles without mem_rvalid_i before an error completion (legal range 1..65535).
REQ-002 clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 if_mem_req_i  input  1  IFU MMU page-table read request; level, held until if_mem_rvalid_o.
REQ-005 if_mem_addr_i  input  32  IFU PTE physical address; stable while if_mem_req_i=1.
REQ-006 if_mem_rdata_o / if_mem_rvalid_o / if_mem_err_o  output  32/1/1  IFU PTE data, 1-cycle completion pulse, error flag valid with the pulse.
REQ-007 ls_mem_req_i / ls_mem_addr_i  input  1/32  LSU MMU request and address; same rules as IFU.
REQ-008 ls_mem_rdata_o / ls_mem_rvalid_o / ls_mem_err_o  output  32/1/1  LSU completion; same rules as IFU.
REQ-009 if_flush_i  input  1  abort the IFU walk: pipeline redirect or MMU flush.
REQ-010 mem_req_valid_o / mem_addr_o  output  1/32  shared memory read request.
REQ-011 mem_req_ready_i  input  1  memory accepts the request when valid&ready.
REQ-012 mem_rdata_i / mem_rvalid_i  input  32/1  read response; at most one outstanding.
REQ-013 busy_o  output  1  high whenever state != IDLE.

Function
REQ-014 States: IDLE, REQ, WAIT, DRAIN; 1-bit owner (0=IFU, 1=LSU); 1-bit rr_last (last owner served); 32-bit addr latch; 16-bit wait counter.
REQ-015 IDLE: single requester -> latch its address, set owner, go to REQ next cycle.
REQ-016 IDLE, both requesting: grant the requester != rr_last.
REQ-017 REQ: mem_req_valid_o=1, mem_addr_o=latched address; valid&ready -> WAIT and clear counter; valid is held (address stable) until accepted.
REQ-018 WAIT: mem_rvalid_i -> owner's rvalid=1 and rdata=mem_rdata_i in the same cycle (combinational pass-through), err=0; rr_last<=owner; -> IDLE.
REQ-019 WAIT without mem_rvalid_i: counter increments; when counter==TIMEOUT-1 with no response, owner's rvalid=1, err=1, rdata=0 that cycle; -> DRAIN.
REQ-020 DRAIN: waits for mem_rvalid_i, discards it (no completion pulse to either requester) -> IDLE.
REQ-021 if_flush_i with owner=IFU in REQ: drop the request without a completion pulse -> IDLE; mem_req_valid_o is 0 from the next cycle.
REQ-022 if_flush_i with owner=IFU in WAIT: -> DRAIN; no IFU completion pulse, even if mem_rvalid_i arrives in the same cycle (that response is discarded and the state goes to IDLE).
REQ-023 if_flush_i in IDLE: an IFU request is not granted that cycle; LSU may still be granted.
REQ-024 if_flush_i never affects an LSU-owned transaction.
REQ-025 At most one rvalid pulse per grant; rvalid is never asserted to the non-owner.
REQ-026 A requester drops req the cycle after its rvalid pulse; the arbiter is in IDLE that cycle, so back-to-back grants have a 1-cycle IDLE gap.
REQ-027 Outputs not being actively driven are 0: rdata, rvalid and err to the non-owner; mem_addr_o outside REQ.

Reset
REQ-028 rst=1 at a clock edge: state=IDLE, owner=0, rr_last=1 (IFU wins the first tie), counter=0, addr latch=0.
REQ-029 After reset, all outputs are 0.
REQ-030 Reset mid-transaction abandons it with no completion pulse; a later stray mem_rvalid_i in IDLE is ignored.

Verification
REQ-031 IFU req addr 0x8000_1000, ready=1, rvalid 3 cycles later with data 0x2000_0CF1 -> mem_addr_o=0x8000_1000, if_mem_rvalid_o pulses once with 0x2000_0CF1, err=0, busy_o low the next cycle.
REQ-032 IFU and LSU requesting simultaneously after reset -> IFU served first, LSU second; second simultaneous pair after that -> the requester != rr_last is served first.
REQ-033 mem_req_ready_i held low for 5 cycles -> mem_req_valid_o stays 1 with a constant address; accepted on the 6th cycle.
REQ-034 IFU in WAIT, if_flush_i pulse, rvalid 2 cycles later -> no if_mem_rvalid_o; the arbiter returns to IDLE the cycle after rvalid; a pending LSU request is granted next.
REQ-035 TIMEOUT=4, no response -> owner gets rvalid=1, err=1, rdata=0 on the 4th WAIT cycle; the late rvalid is discarded in DRAIN.
REQ-036 rst asserted in WAIT -> all outputs 0 next cycle, no completion pulse; a subsequent stray mem_rvalid_i produces no output.
